// File: rtl/accum_adder_display.sv
// Accumulating adder/subtractor with sticky overflow flag and a multiplexed
// hex display of the accumulator.
//
// Parameters:
//   WIDTH       - accumulator/operand width, multiple of 4, 4..32
//   SIGNED      - 1: two's-complement overflow, 0: unsigned carry/borrow
//   REFRESH_DIV - clock cycles each display digit stays active (>= 1)
// Ports:
//   CLK100MHZ - clock, all state rising-edge triggered
//   RST       - asynchronous active-high reset
//   DIN       - operand, sampled on the operation cycle
//   STEP      - asynchronous operation request, one operation per rising edge
//   SUB       - 0 = add, 1 = subtract, sampled on the operation cycle
//   SUM       - accumulator register
//   LEDR      - sticky overflow flag
//   HEX0      - active-low segments, index 0 = a ... index 6 = g
//   AN        - active-low digit anodes
module accum_adder_display #(
  parameter int unsigned WIDTH       = 8,
  parameter bit          SIGNED      = 1'b1,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic             CLK100MHZ,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             STEP,
  input  logic             SUB,
  output logic [WIDTH-1:0] SUM,
  output logic             LEDR,
  output logic [0:6]       HEX0,
  output logic [7:0]       AN
);

  localparam int unsigned NDIG = WIDTH / 4;
  localparam int unsigned CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CntMax = CW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DigMax = DW'(NDIG - 1);

  // STEP synchroniser and edge detector
  logic s1_q, s2_q, s3_q;
  // v1/v2 mark that s1/s2 hold genuine post-reset samples of STEP
  logic v1_q, v2_q;
  // Armed once a genuine low STEP has been seen since reset, so a STEP that
  // is already high when reset releases cannot trigger an operation.
  logic armed_q, armed_d;
  logic pulse;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] result;
  logic             ovf_now;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] digit_q, digit_d;
  logic [3:0]    nibble;

  assign pulse   = s2_q & ~s3_q & armed_q;
  assign armed_d = armed_q | (v2_q & ~s2_q);

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= STEP;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      v1_q    <= 1'b1;
      v2_q    <= v1_q;
      armed_q <= armed_d;
    end
  end

  // Arithmetic and overflow detection
  always_comb begin
    add_full = {1'b0, sum_q} + {1'b0, DIN};
    sub_full = {1'b0, sum_q} - {1'b0, DIN};
    result   = SUB ? sub_full[WIDTH-1:0] : add_full[WIDTH-1:0];
    ovf_now  = 1'b0;
    if (SIGNED) begin
      if (SUB) begin
        ovf_now = (sum_q[WIDTH-1] ^ DIN[WIDTH-1]) & (result[WIDTH-1] ^ sum_q[WIDTH-1]);
      end else begin
        ovf_now = ~(sum_q[WIDTH-1] ^ DIN[WIDTH-1]) & (result[WIDTH-1] ^ sum_q[WIDTH-1]);
      end
    end else begin
      // Borrow out of the extended subtraction is exactly DIN > SUM
      ovf_now = SUB ? sub_full[WIDTH] : add_full[WIDTH];
    end
  end

  always_comb begin
    sum_d = sum_q;
    ovf_d = ovf_q;
    if (pulse) begin
      sum_d = result;
      ovf_d = ovf_q | ovf_now;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign SUM  = sum_q;
  assign LEDR = ovf_q;

  // Display scan
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    if (cnt_q == CntMax) begin
      cnt_d   = '0;
      digit_d = (digit_q == DigMax) ? '0 : digit_q + 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      digit_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  always_comb begin
    nibble = 4'(sum_q >> {digit_q, 2'b00});
    AN     = ~(8'b1 << digit_q);
  end

  // Segment literals are written a..g left to right
  always_comb begin
    HEX0 = 7'b1111111;
    unique case (nibble)
      4'h0: HEX0 = 7'b0000001;
      4'h1: HEX0 = 7'b1001111;
      4'h2: HEX0 = 7'b0010010;
      4'h3: HEX0 = 7'b0000110;
      4'h4: HEX0 = 7'b1001100;
      4'h5: HEX0 = 7'b0100100;
      4'h6: HEX0 = 7'b0100000;
      4'h7: HEX0 = 7'b0001111;
      4'h8: HEX0 = 7'b0000000;
      4'h9: HEX0 = 7'b0000100;
      4'hA: HEX0 = 7'b0001000;
      4'hB: HEX0 = 7'b1100000;
      4'hC: HEX0 = 7'b0110001;
      4'hD: HEX0 = 7'b1000010;
      4'hE: HEX0 = 7'b0110000;
      4'hF: HEX0 = 7'b0111000;
      default: HEX0 = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_accum_adder_display.sv
module tb_accum_adder_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       step = 1'b0;
  logic       sub = 1'b0;

  logic [7:0] sum_s, sum_u;
  logic       ledr_s, ledr_u;
  logic [0:6] hex_s, hex_u;
  logic [7:0] an_s, an_u;

  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  accum_adder_display #(.WIDTH(8), .SIGNED(1'b1), .REFRESH_DIV(4)) dut_s (
    .CLK100MHZ(clk), .RST(rst), .DIN(din), .STEP(step), .SUB(sub),
    .SUM(sum_s), .LEDR(ledr_s), .HEX0(hex_s), .AN(an_s)
  );

  accum_adder_display #(.WIDTH(8), .SIGNED(1'b0), .REFRESH_DIV(4)) dut_u (
    .CLK100MHZ(clk), .RST(rst), .DIN(din), .STEP(step), .SUB(sub),
    .SUM(sum_u), .LEDR(ledr_u), .HEX0(hex_u), .AN(an_u)
  );

  typedef struct {
    logic       rst_first;
    logic [7:0] din;
    logic       sub;
    logic [7:0] sum;
    logic       ovf_s;
    logic       ovf_u;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_sum_s", {24'b0, sum_s}, 32'h00);
    chk("rst_ledr_s", {31'b0, ledr_s}, 32'h0);
    chk("rst_an_s", {24'b0, an_s}, 32'hFE);
    chk("rst_hex_s", {25'b0, hex_s}, 32'b0000001);
    chk("rst_sum_u", {24'b0, sum_u}, 32'h00);
    chk("rst_ledr_u", {31'b0, ledr_u}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_op(input logic [7:0] d, input logic s);
    @(negedge clk);
    din  = d;
    sub  = s;
    step = 1'b1;
    repeat (3) @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] prev;
    int         changes;
    int         chg_at;
    bit         ok;

    //               rst   din    sub   sum    ovf_s ovf_u
    vecs[0] = '{1'b1, 8'hD1, 1'b0, 8'hD1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h89, 1'b0, 8'h5A, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 8'h01, 1'b0, 8'h5B, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h02, 1'b0, 8'h01, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h80, 1'b1, 8'h81, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 8'h7F, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h01, 1'b0, 8'h80, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rst_first) apply_reset();
      do_op(vecs[i].din, vecs[i].sub);
      chk($sformatf("v%0d_sum_s", i), {24'b0, sum_s}, {24'b0, vecs[i].sum});
      chk($sformatf("v%0d_ledr_s", i), {31'b0, ledr_s}, {31'b0, vecs[i].ovf_s});
      chk($sformatf("v%0d_sum_u", i), {24'b0, sum_u}, {24'b0, vecs[i].sum});
      chk($sformatf("v%0d_ledr_u", i), {31'b0, ledr_u}, {31'b0, vecs[i].ovf_u});
    end

    // Latency: STEP held 20 cycles, one update at edge n+2, DIN/SUB churn ignored
    apply_reset();
    @(negedge clk);
    din  = 8'h05;
    sub  = 1'b0;
    step = 1'b1;
    prev = sum_s;
    changes = 0;
    chg_at = -1;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk);
      #1;
      if (sum_s !== prev) begin
        changes++;
        chg_at = i;
        prev = sum_s;
      end
      if (i == 5) begin
        din = 8'h77;
        sub = 1'b1;
      end
      if (i == 19) step = 1'b0;
    end
    chk("lat_changes", changes, 1);
    chk("lat_edge", chg_at, 2);
    chk("lat_sum", {24'b0, sum_s}, 32'h05);
    chk("lat_ledr", {31'b0, ledr_s}, 32'h0);
    repeat (4) @(negedge clk);

    // Scan with SUM = 5A
    apply_reset();
    do_op(8'h5A, 1'b0);
    chk("scan_sum", {24'b0, sum_s}, 32'h5A);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (an_s == 8'hFD) ok = 1'b1;
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge clk);
        if (an_s == 8'hFE) ok = 1'b1;
      end
    end
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL scan_sync: got an=%0h, expected an to toggle FD->FE", an_s);
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (i < 4 || i == 8) begin
          chk($sformatf("scan%0d_an", i), {24'b0, an_s}, 32'hFE);
          chk($sformatf("scan%0d_hex", i), {25'b0, hex_s}, 32'b0001000);
        end else begin
          chk($sformatf("scan%0d_an", i), {24'b0, an_s}, 32'hFD);
          chk($sformatf("scan%0d_hex", i), {25'b0, hex_s}, 32'b0100100);
        end
        if (i < 8) @(negedge clk);
      end
    end

    // Reset between STEP edge and update, STEP still high after release
    @(negedge clk);
    din  = 8'h01;
    sub  = 1'b0;
    step = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_sum_s", {24'b0, sum_s}, 32'h00);
    chk("midrst_ledr_s", {31'b0, ledr_s}, 32'h0);
    chk("midrst_sum_u", {24'b0, sum_u}, 32'h00);
    step = 1'b0;
    repeat (4) @(negedge clk);
    do_op(8'h03, 1'b0);
    chk("rearm_sum_s", {24'b0, sum_s}, 32'h03);
    chk("rearm_ledr_s", {31'b0, ledr_s}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
